// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32I pipeline control blocks.
package riscv_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } hz_state_t;

endpackage

// File: rtl/fwd_unit.sv
// Execute-stage operand forwarding select for one source register.
module fwd_unit
  import riscv_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_m_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_w_i,
  input  logic                      reg_write_m_i,
  input  logic                      reg_write_w_i,
  output fwd_sel_t                  sel_o
);

  localparam logic [REG_ADDR_WIDTH-1:0] ZERO = REG_ADDR_WIDTH'(REG_ZERO);

  // The M stage holds the younger result, so it takes priority over W.
  always_comb begin
    sel_o = FWD_RF;
    if (reg_write_m_i && (rd_m_i != ZERO) && (rd_m_i == rs_i)) begin
      sel_o = FWD_M;
    end else if (reg_write_w_i && (rd_w_i != ZERO) && (rd_w_i == rs_i)) begin
      sel_o = FWD_W;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: load-use stalls, branch flushes, mul/div hold with watchdog, forwarding.
module pipeline_hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned MD_MAX_CYCLES  = 34,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
  input  logic [REG_ADDR_WIDTH-1:0] RdE,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic                      RegWriteM,
  input  logic                      RegWriteW,
  input  logic                      LoadE,
  input  logic                      PCSrcE,
  input  logic                      MdStartE,
  input  logic                      MdDoneE,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      StallE,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic                      FlushM,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE,
  output logic                      md_timeout,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt
);

  localparam int unsigned MDW = $clog2(MD_MAX_CYCLES + 1);
  localparam logic [MDW-1:0] MD_LIMIT = MDW'(MD_MAX_CYCLES - 1);
  localparam logic [REG_ADDR_WIDTH-1:0] ZERO = REG_ADDR_WIDTH'(REG_ZERO);

  hz_state_t            state_q;
  logic [MDW-1:0]       md_cnt_q;
  logic                 md_timeout_q;
  logic [CNT_WIDTH-1:0] stall_cnt_q;
  logic [CNT_WIDTH-1:0] flush_cnt_q;

  logic     lw_stall;
  logic     md_hold;
  logic     md_expire;
  fwd_sel_t fwd_a;
  fwd_sel_t fwd_b;

  fwd_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
    .rs_i         (Rs1E),
    .rd_m_i       (RdM),
    .rd_w_i       (RdW),
    .reg_write_m_i(RegWriteM),
    .reg_write_w_i(RegWriteW),
    .sel_o        (fwd_a)
  );

  fwd_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
    .rs_i         (Rs2E),
    .rd_m_i       (RdM),
    .rd_w_i       (RdW),
    .reg_write_m_i(RegWriteM),
    .reg_write_w_i(RegWriteW),
    .sel_o        (fwd_b)
  );

  // MdDoneE releases the pipeline in the same cycle, so the hold drops combinationally.
  always_comb begin
    lw_stall  = LoadE && (RdE != ZERO) && ((RdE == Rs1D) || (RdE == Rs2D));
    md_hold   = (state_q == MD_BUSY) && !MdDoneE;
    md_expire = md_hold && (md_cnt_q == MD_LIMIT);

    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    ForwardAE = fwd_a;
    ForwardBE = fwd_b;

    if (rst) begin
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
    end else if (md_hold) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else begin
      // A taken branch discards the stalled instruction, so it overrides the load-use stall.
      StallF = lw_stall && !PCSrcE;
      StallD = lw_stall && !PCSrcE;
      FlushD = PCSrcE;
      FlushE = PCSrcE || lw_stall;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      md_cnt_q     <= '0;
      md_timeout_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (MdStartE && !PCSrcE) begin
            state_q  <= MD_BUSY;
            md_cnt_q <= '0;
          end
        end
        MD_BUSY: begin
          if (md_cnt_q != '1) begin
            md_cnt_q <= md_cnt_q + MDW'(1);
          end
          if (MdDoneE) begin
            state_q <= RUN;
          end else if (md_expire) begin
            state_q      <= RUN;
            md_timeout_q <= 1'b1;
          end
        end
        default: state_q <= RUN;
      endcase

      if (StallF && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      end
      if (FlushD && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign md_timeout = md_timeout_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and randomized checks of pipeline_hazard_ctrl against an in-bench behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int MAXC = 34;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteM, RegWriteW, LoadE, PCSrcE, MdStartE, MdDoneE;
  logic StallF, StallD, StallE, FlushD, FlushE, FlushM;
  logic [1:0] ForwardAE, ForwardBE;
  logic md_timeout;
  logic [31:0] stall_cnt, flush_cnt;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .REG_ADDR_WIDTH(5),
    .MD_MAX_CYCLES (MAXC),
    .CNT_WIDTH     (32)
  ) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .MdStartE(MdStartE), .MdDoneE(MdDoneE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .md_timeout(md_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit sf, sd, se, fd, fe, fm;
    bit [1:0] fa, fb;
  } exp_t;

  bit          started = 0;
  bit          m_busy = 0;
  int          m_cycles = 0;
  bit          m_to = 0;
  longint      m_stall = 0;
  longint      m_flush = 0;
  localparam longint CMAX = 64'hFFFF_FFFF;

  function automatic bit [1:0] fwd(input bit [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    bit hazard;
    e = '{default: 0};
    if (rst) begin
      e.fd = 1;
      e.fe = 1;
      return e;
    end
    e.fa = fwd(Rs1E);
    e.fb = fwd(Rs2E);
    hazard = LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    if (m_busy && !MdDoneE) begin
      e.sf = 1; e.sd = 1; e.se = 1; e.fm = 1;
    end else if (PCSrcE) begin
      e.fd = 1; e.fe = 1;
    end else begin
      e.sf = hazard; e.sd = hazard; e.fe = hazard;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    e = expect_now();
    started = 1;
    if (rst) begin
      m_busy = 0; m_cycles = 0; m_to = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (e.sf && m_stall != CMAX) m_stall++;
      if (e.fd && m_flush != CMAX) m_flush++;
      if (!m_busy) begin
        if (MdStartE && !PCSrcE) begin
          m_busy = 1;
          m_cycles = 0;
        end
      end else if (MdDoneE) begin
        m_busy = 0;
      end else if (m_cycles == MAXC - 1) begin
        m_busy = 0;
        m_to = 1;
      end else begin
        m_cycles++;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      e = expect_now();
      chk("StallF", StallF, e.sf);
      chk("StallD", StallD, e.sd);
      chk("StallE", StallE, e.se);
      chk("FlushD", FlushD, e.fd);
      chk("FlushE", FlushE, e.fe);
      chk("FlushM", FlushM, e.fm);
      chk("ForwardAE", ForwardAE, e.fa);
      chk("ForwardBE", ForwardBE, e.fb);
      chk("md_timeout", md_timeout, m_to);
      chk("stall_cnt", stall_cnt, m_stall);
      chk("flush_cnt", flush_cnt, m_flush);
    end
  end

  // ---------------- stimulus ----------------
  task automatic clr();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; LoadE = 0; PCSrcE = 0; MdStartE = 0; MdDoneE = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
    $fatal(1);
  end

  initial begin
    rst = 1;
    clr();
    @(negedge clk);
    chk("rst_FlushD", FlushD, 1);
    chk("rst_FlushE", FlushE, 1);
    chk("rst_StallF", StallF, 0);
    tick();
    tick();
    rst = 0;
    @(negedge clk);
    chk("idle_stall_cnt", stall_cnt, 0);
    chk("idle_FlushD", FlushD, 0);
    chk("idle_ForwardAE", ForwardAE, 0);

    tick(); LoadE = 1; RdE = 5; Rs1D = 5;
    @(negedge clk);
    chk("lu_StallF", StallF, 1);
    chk("lu_StallD", StallD, 1);
    chk("lu_FlushE", FlushE, 1);
    tick(); clr();
    @(negedge clk);
    chk("lu_stall_cnt", stall_cnt, 1);
    tick(); LoadE = 1; RdE = 0; Rs1D = 0;
    @(negedge clk);
    chk("lu_x0_StallF", StallF, 0);

    tick(); clr();
    RegWriteM = 1; RdM = 3; RegWriteW = 1; RdW = 3; Rs1E = 3; Rs2E = 3;
    @(negedge clk);
    chk("fwd_M_A", ForwardAE, 2);
    chk("fwd_M_B", ForwardBE, 2);
    tick(); RegWriteM = 0;
    @(negedge clk);
    chk("fwd_W_A", ForwardAE, 1);
    chk("fwd_W_B", ForwardBE, 1);

    tick(); clr(); MdStartE = 1;
    @(negedge clk);
    chk("md_start_StallE", StallE, 0);
    tick(); MdStartE = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("md_busy_StallE", StallE, 1);
      chk("md_busy_FlushM", FlushM, 1);
      tick();
    end
    MdDoneE = 1;
    @(negedge clk);
    chk("md_done_StallE", StallE, 0);
    chk("md_done_StallF", StallF, 0);
    tick(); clr();
    @(negedge clk);
    chk("md_stall_cnt", stall_cnt, 6);

    tick(); LoadE = 1; RdE = 5; Rs1D = 5; PCSrcE = 1;
    @(negedge clk);
    chk("br_FlushD", FlushD, 1);
    chk("br_FlushE", FlushE, 1);
    chk("br_StallF", StallF, 0);
    tick(); clr();
    @(negedge clk);
    chk("br_flush_cnt", flush_cnt, 1);

    tick(); MdStartE = 1;
    @(negedge clk);
    chk("to_pre", md_timeout, 0);
    tick(); clr();
    for (int i = 0; i < MAXC; i++) begin
      @(negedge clk);
      chk("to_busy_StallE", StallE, 1);
      tick();
    end
    @(negedge clk);
    chk("to_exit_StallE", StallE, 0);
    chk("to_flag", md_timeout, 1);
    chk("to_stall_cnt", stall_cnt, 40);
    tick();
    @(negedge clk);
    chk("to_sticky", md_timeout, 1);

    for (int n = 0; n < 3000; n++) begin
      tick();
      rst       = ($urandom_range(0, 59) == 0);
      Rs1D      = 5'($urandom_range(0, 3));
      Rs2D      = 5'($urandom_range(0, 3));
      Rs1E      = 5'($urandom_range(0, 3));
      Rs2E      = 5'($urandom_range(0, 3));
      RdE       = 5'($urandom_range(0, 3));
      RdM       = 5'($urandom_range(0, 3));
      RdW       = 5'($urandom_range(0, 3));
      RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      LoadE     = ($urandom_range(0, 2) == 0);
      PCSrcE    = ($urandom_range(0, 4) == 0);
      MdStartE  = ($urandom_range(0, 5) == 0);
      MdDoneE   = ($urandom_range(0, 11) == 0);
    end
    tick();
    rst = 0;
    clr();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
